// File: rtl/fifo_tx_pkg.sv
// Shared types and constants for the nibble-FIFO UART drain stage.
package fifo_tx_pkg;

   typedef enum logic [2:0] {
      S_IDLE     = 3'd0,
      S_RD_REQ   = 3'd1,
      S_RD_GAP   = 3'd2,
      S_TX_START = 3'd3,
      S_TX_DATA  = 3'd4,
      S_TX_STOP  = 3'd5
   } state_t;

   localparam logic [9:0] FRAME_BITS = 10'd10;
   localparam logic       START_LVL  = 1'b0;
   localparam logic       STOP_LVL   = 1'b1;
   localparam bit         LOW_FIRST  = 1'b1;

   // First nibble read from the FIFO lands in bits [3:0] when LOW_FIRST is set.
   function automatic logic [7:0] pack_nibbles(input logic [3:0] first, input logic [3:0] second);
      return LOW_FIRST ? {second, first} : {first, second};
   endfunction

endpackage

// File: rtl/uart_tx_core.sv
// 8N1 UART transmitter: latches a byte on start, shifts it out LSB first.
//   state      | meaning
//   S_IDLE     | line idle high, waiting for start
//   S_TX_START | start bit, CLKS_PER_BIT cycles low
//   S_TX_DATA  | 8 data bits, LSB first
//   S_TX_STOP  | stop bit high; done pulses on its last cycle
module uart_tx_core
   import fifo_tx_pkg::*;
#(
   parameter int CLKS_PER_BIT = 868
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   input  logic [7:0] data,
   output logic       tx,
   output logic       busy,
   output logic       done
);

   localparam int             BW        = $clog2(CLKS_PER_BIT);
   localparam logic [BW-1:0]  BAUD_RLD  = BW'(CLKS_PER_BIT - 1);
   localparam int             DATA_BITS = int'(FRAME_BITS) - 2;
   localparam logic [2:0]     LAST_BIT  = 3'(DATA_BITS - 1);

   state_t          state_q, state_d;
   logic [BW-1:0]   baud_q, baud_d;
   logic [2:0]      bit_q, bit_d;
   logic [7:0]      shreg_q, shreg_d;
   logic            tx_q, tx_d;
   logic            baud_tc;

   assign baud_tc = (baud_q == '0);
   assign tx      = tx_q;
   assign busy    = (state_q != S_IDLE);

   always_comb begin
      state_d = state_q;
      baud_d  = baud_q;
      bit_d   = bit_q;
      shreg_d = shreg_q;
      tx_d    = tx_q;
      done    = 1'b0;
      case (state_q)
         S_IDLE: begin
            tx_d = STOP_LVL;
            if (start) begin
               state_d = S_TX_START;
               tx_d    = START_LVL;
               baud_d  = BAUD_RLD;
               shreg_d = data;
            end
         end
         S_TX_START: begin
            if (baud_tc) begin
               state_d = S_TX_DATA;
               baud_d  = BAUD_RLD;
               bit_d   = 3'd0;
               tx_d    = shreg_q[0];
            end else begin
               baud_d = baud_q - BW'(1);
            end
         end
         S_TX_DATA: begin
            if (baud_tc) begin
               baud_d = BAUD_RLD;
               bit_d  = bit_q + 3'd1;
               if (bit_q == LAST_BIT) begin
                  state_d = S_TX_STOP;
                  tx_d    = STOP_LVL;
               end else begin
                  tx_d = shreg_q[bit_d];
               end
            end else begin
               baud_d = baud_q - BW'(1);
            end
         end
         S_TX_STOP: begin
            if (baud_tc) begin
               state_d = S_IDLE;
               done    = 1'b1;
            end else begin
               baud_d = baud_q - BW'(1);
            end
         end
         default: begin
            state_d = S_IDLE;
            tx_d    = STOP_LVL;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         baud_q  <= '0;
         bit_q   <= '0;
         shreg_q <= '0;
         tx_q    <= STOP_LVL;
      end else begin
         state_q <= state_d;
         baud_q  <= baud_d;
         bit_q   <= bit_d;
         shreg_q <= shreg_d;
         tx_q    <= tx_d;
      end
   end

endmodule

// File: rtl/fifo_nibble_uart_tx.sv
// Drains a nibble FIFO through a synchronised read handshake, packs nibble pairs, sends bytes over UART.
//   state      | meaning
//   S_IDLE     | waiting for data (enable, !fifo_empty) or a flush of a held nibble
//   S_RD_REQ   | fifo_rd_en high for RD_LAT cycles; data captured on the last one
//   S_RD_GAP   | fifo_rd_en low for RD_GAP cycles so the FIFO sees a fresh edge
//   S_TX_START | byte handed to uart_tx_core; waits for its frame to finish
module fifo_nibble_uart_tx
   import fifo_tx_pkg::*;
#(
   parameter int CLKS_PER_BIT = 868,
   parameter int RD_LAT       = 4,
   parameter int RD_GAP       = 3
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       enable,
   input  logic       flush,
   input  logic       fifo_empty,
   input  logic [3:0] fifo_rd_data,
   output logic       fifo_rd_en,
   output logic       tx,
   output logic       busy,
   output logic       nib_held
);

   localparam int CNT_MAX = (RD_LAT > RD_GAP) ? RD_LAT : RD_GAP;
   localparam int CW      = $clog2(CNT_MAX + 1);

   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [3:0]    low_q, low_d;
   logic          held_q, held_d;
   logic [7:0]    byte_q, byte_d;
   logic          pend_q, pend_d;
   logic          rd_en_q;
   logic          core_start, core_busy, core_done;
   logic [7:0]    core_byte;

   assign fifo_rd_en = rd_en_q;
   assign nib_held   = held_q;
   assign busy       = (state_q != S_IDLE) | core_busy;

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      low_d      = low_q;
      held_d     = held_q;
      byte_d     = byte_q;
      pend_d     = pend_q;
      core_start = 1'b0;
      core_byte  = byte_q;
      case (state_q)
         S_IDLE: begin
            if (enable && !fifo_empty) begin
               state_d = S_RD_REQ;
               cnt_d   = CW'(RD_LAT - 1);
            end else if (flush && held_q) begin
               core_start = 1'b1;
               core_byte  = pack_nibbles(low_q, 4'h0);
               held_d     = 1'b0;
               state_d    = S_TX_START;
            end
         end
         S_RD_REQ: begin
            if (cnt_q == '0) begin
               if (!held_q) begin
                  low_d  = fifo_rd_data;
                  held_d = 1'b1;
               end else begin
                  byte_d = pack_nibbles(low_q, fifo_rd_data);
                  held_d = 1'b0;
                  pend_d = 1'b1;
               end
               cnt_d   = CW'(RD_GAP - 1);
               state_d = S_RD_GAP;
            end else begin
               cnt_d = cnt_q - CW'(1);
            end
         end
         S_RD_GAP: begin
            if (cnt_q == '0) begin
               if (pend_q) begin
                  core_start = 1'b1;
                  pend_d     = 1'b0;
                  state_d    = S_TX_START;
               end else begin
                  state_d = S_IDLE;
               end
            end else begin
               cnt_d = cnt_q - CW'(1);
            end
         end
         S_TX_START: begin
            if (core_done) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         low_q   <= '0;
         held_q  <= 1'b0;
         byte_q  <= '0;
         pend_q  <= 1'b0;
         rd_en_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         low_q   <= low_d;
         held_q  <= held_d;
         byte_q  <= byte_d;
         pend_q  <= pend_d;
         rd_en_q <= (state_d == S_RD_REQ);
      end
   end

   uart_tx_core #(
      .CLKS_PER_BIT (CLKS_PER_BIT)
   ) u_uart_tx_core (
      .clk   (clk),
      .rst_n (rst_n),
      .start (core_start),
      .data  (core_byte),
      .tx    (tx),
      .busy  (core_busy),
      .done  (core_done)
   );

endmodule

// File: tb/tb_fifo_nibble_uart_tx.sv
// Directed bench for fifo_nibble_uart_tx with a synchronised-read nibble FIFO model and a UART frame sampler.
module tb_fifo_nibble_uart_tx;

   localparam int CPB    = 4;
   localparam int RD_LAT = 4;
   localparam int RD_GAP = 3;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       enable = 1'b0;
   logic       flush = 1'b0;
   logic       fifo_empty;
   logic [3:0] fifo_rd_data = 4'h0;
   logic       fifo_rd_en, tx, busy, nib_held;

   int n_chk = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   fifo_nibble_uart_tx #(
      .CLKS_PER_BIT (CPB),
      .RD_LAT       (RD_LAT),
      .RD_GAP       (RD_GAP)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .enable       (enable),
      .flush        (flush),
      .fifo_empty   (fifo_empty),
      .fifo_rd_data (fifo_rd_data),
      .fifo_rd_en   (fifo_rd_en),
      .tx           (tx),
      .busy         (busy),
      .nib_held     (nib_held)
   );

   // FIFO model: rd_en passes a 2-flop synchroniser, a rising edge pops one nibble.
   logic [3:0] mem [0:15];
   int   wp = 0;
   int   rp = 0;
   logic s1 = 1'b0;
   logic s2 = 1'b0;

   assign fifo_empty = (wp == rp);

   always @(posedge clk) begin
      s1 <= fifo_rd_en;
      s2 <= s1;
      if (s1 && !s2 && (rp != wp)) begin
         fifo_rd_data <= mem[rp[3:0]];
         rp <= rp + 1;
      end
   end

   // Read-strobe shape monitor: counts pulses, wrong-length pulses and short gaps.
   int   mon_pulses = 0;
   int   mon_bad_hi = 0;
   int   mon_bad_gap = 0;
   int   hi_run = 0;
   int   lo_run = 0;
   logic rd_prev = 1'b0;

   always @(negedge clk) begin
      if (fifo_rd_en === 1'b1) begin
         if (!rd_prev && mon_pulses > 0 && lo_run < RD_GAP) mon_bad_gap++;
         hi_run++;
         lo_run = 0;
      end else begin
         if (rd_prev) begin
            mon_pulses++;
            if (hi_run != RD_LAT) mon_bad_hi++;
         end
         hi_run = 0;
         lo_run++;
      end
      rd_prev = (fifo_rd_en === 1'b1);
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic push(input logic [3:0] d);
      mem[wp[3:0]] = d;
      wp = wp + 1;
   endtask

   // Waits for a start bit, then samples one frame; flush is treated as a one-cycle pulse.
   task automatic recv_frame(input int drop_at, output logic [7:0] b, output logic frame_ok,
                             output logic found);
      found    = 1'b0;
      frame_ok = 1'b1;
      b        = 8'h00;
      for (int i = 0; i < 400 && !found; i++) begin
         @(negedge clk);
         flush = 1'b0;
         if (tx === 1'b0) found = 1'b1;
      end
      if (!found) return;
      for (int k = 0; k < 40; k++) begin
         if (k > 0) @(negedge clk);
         if (k == drop_at) enable = 1'b0;
         if (k < 4 && tx !== 1'b0) frame_ok = 1'b0;
         if (k >= 4 && k < 36 && (k % 4) == 2) b = {tx, b[7:1]};
         if (k >= 36 && tx !== 1'b1) frame_ok = 1'b0;
         if (k == 39 && busy !== 1'b1) frame_ok = 1'b0;
      end
   endtask

   task automatic test_reset();
      rst_n  = 1'b0;
      enable = 1'b1;
      repeat (5) @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         n_chk++;
         if ({tx, fifo_rd_en, busy, nib_held} !== 4'b1000) begin
            n_fail++;
            $display("FAIL reset_idle cycle %0d: tx/rd_en/busy/held=%b expected 1000", i,
                     {tx, fifo_rd_en, busy, nib_held});
         end
      end
   endtask

   task automatic test_pair();
      logic [7:0] b;
      logic ok, found;
      int p0, bh0, bg0;
      p0 = mon_pulses; bh0 = mon_bad_hi; bg0 = mon_bad_gap;
      push(4'hA);
      push(4'h5);
      recv_frame(-1, b, ok, found);
      n_chk++;
      if (!found) begin n_fail++; $display("FAIL pair_timeout: no start bit seen"); end
      n_chk++;
      if (b !== 8'h5A) begin n_fail++; $display("FAIL pair_byte: got %h expected 5a", b); end
      n_chk++;
      if (!ok) begin n_fail++; $display("FAIL pair_framing: got bad start/stop expected good"); end
      @(negedge clk);
      n_chk++;
      if ({busy, tx} !== 2'b01) begin
         n_fail++;
         $display("FAIL pair_len: busy/tx after 40 cycles=%b expected 01", {busy, tx});
      end
      n_chk++;
      if (mon_pulses - p0 != 2) begin
         n_fail++;
         $display("FAIL pair_pulses: got %0d expected 2", mon_pulses - p0);
      end
      n_chk++;
      if ((mon_bad_hi - bh0) + (mon_bad_gap - bg0) != 0) begin
         n_fail++;
         $display("FAIL pair_pulse_shape: got %0d bad widths %0d short gaps expected 0",
                  mon_bad_hi - bh0, mon_bad_gap - bg0);
      end
      n_chk++;
      if (nib_held !== 1'b0) begin n_fail++; $display("FAIL pair_held: got %b expected 0", nib_held); end
   endtask

   task automatic test_flush();
      logic [7:0] b;
      logic ok, found;
      int bad;
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      bad = 0;
      repeat (20) begin
         @(negedge clk);
         if (busy !== 1'b0 || tx !== 1'b1) bad++;
      end
      n_chk++;
      if (bad != 0) begin n_fail++; $display("FAIL flush_noop: got %0d busy cycles expected 0", bad); end
      push(4'h3);
      found = 1'b0;
      for (int i = 0; i < 50 && !found; i++) begin
         @(negedge clk);
         if (nib_held === 1'b1) found = 1'b1;
      end
      n_chk++;
      if (!found) begin n_fail++; $display("FAIL flush_held: got nib_held=%b expected 1", nib_held); end
      found = 1'b0;
      for (int i = 0; i < 50 && !found; i++) begin
         @(negedge clk);
         if (busy === 1'b0) found = 1'b1;
      end
      n_chk++;
      if (!found) begin n_fail++; $display("FAIL flush_idle: got busy=%b expected 0", busy); end
      flush = 1'b1;
      recv_frame(-1, b, ok, found);
      n_chk++;
      if (!found || !ok || b !== 8'h03) begin
         n_fail++;
         $display("FAIL flush_byte: got %h (found %b ok %b) expected 03", b, found, ok);
      end
      n_chk++;
      if (nib_held !== 1'b0) begin n_fail++; $display("FAIL flush_clear: got %b expected 0", nib_held); end
   endtask

   task automatic test_back_to_back();
      logic [7:0] b;
      logic ok, found;
      logic [7:0] exp_b [4];
      int p0, bh0, bg0;
      exp_b = '{8'h21, 8'h43, 8'h65, 8'h87};
      @(negedge clk);
      p0 = mon_pulses; bh0 = mon_bad_hi; bg0 = mon_bad_gap;
      for (int n = 1; n <= 8; n++) push(4'(n));
      for (int f = 0; f < 4; f++) begin
         recv_frame(-1, b, ok, found);
         n_chk++;
         if (!found || !ok || b !== exp_b[f]) begin
            n_fail++;
            $display("FAIL b2b_frame%0d: got %h (found %b ok %b) expected %h", f, b, found, ok, exp_b[f]);
         end
      end
      @(negedge clk);
      n_chk++;
      if ({fifo_empty, nib_held, busy} !== 3'b100) begin
         n_fail++;
         $display("FAIL b2b_end: empty/held/busy=%b expected 100", {fifo_empty, nib_held, busy});
      end
      n_chk++;
      if (mon_pulses - p0 != 8 || mon_bad_hi != bh0 || mon_bad_gap != bg0) begin
         n_fail++;
         $display("FAIL b2b_pulses: got %0d pulses %0d bad expected 8 pulses 0 bad",
                  mon_pulses - p0, (mon_bad_hi - bh0) + (mon_bad_gap - bg0));
      end
   endtask

   task automatic test_enable();
      logic [7:0] b;
      logic ok, found;
      int bad;
      enable = 1'b0;
      push(4'h9);
      push(4'hC);
      bad = 0;
      repeat (200) begin
         @(negedge clk);
         if (fifo_rd_en !== 1'b0 || busy !== 1'b0) bad++;
      end
      n_chk++;
      if (bad != 0) begin n_fail++; $display("FAIL en_gate: got %0d active cycles expected 0", bad); end
      n_chk++;
      if (fifo_empty !== 1'b0) begin n_fail++; $display("FAIL en_kept: got empty=%b expected 0", fifo_empty); end
      enable = 1'b1;
      recv_frame(-1, b, ok, found);
      n_chk++;
      if (!found || !ok || b !== 8'hC9) begin
         n_fail++;
         $display("FAIL en_resume: got %h (found %b ok %b) expected c9", b, found, ok);
      end
      push(4'hE); push(4'h7); push(4'hB); push(4'h2);
      recv_frame(10, b, ok, found);
      n_chk++;
      if (!found || !ok || b !== 8'h7E) begin
         n_fail++;
         $display("FAIL en_drop_mid: got %h (found %b ok %b) expected 7e", b, found, ok);
      end
      bad = 0;
      repeat (100) begin
         @(negedge clk);
         if (fifo_rd_en !== 1'b0 || tx !== 1'b1) bad++;
      end
      n_chk++;
      if (bad != 0 || fifo_empty !== 1'b0) begin
         n_fail++;
         $display("FAIL en_drop_gate: got %0d active cycles empty=%b expected 0 and 0", bad, fifo_empty);
      end
      enable = 1'b1;
      recv_frame(-1, b, ok, found);
      n_chk++;
      if (!found || !ok || b !== 8'h2B) begin
         n_fail++;
         $display("FAIL en_second: got %h (found %b ok %b) expected 2b", b, found, ok);
      end
      @(negedge clk);
   endtask

   task automatic test_reset_mid_frame();
      logic found;
      int bad;
      push(4'h4);
      push(4'h6);
      found = 1'b0;
      for (int i = 0; i < 200 && !found; i++) begin
         @(negedge clk);
         if (tx === 1'b0) found = 1'b1;
      end
      n_chk++;
      if (!found) begin n_fail++; $display("FAIL rstmid_start: no start bit seen"); end
      repeat (17) @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      n_chk++;
      if ({tx, busy, nib_held, fifo_rd_en} !== 4'b1000) begin
         n_fail++;
         $display("FAIL rstmid_abort: tx/busy/held/rd_en=%b expected 1000", {tx, busy, nib_held, fifo_rd_en});
      end
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      bad = 0;
      repeat (100) begin
         @(negedge clk);
         if (tx !== 1'b1 || busy !== 1'b0) bad++;
      end
      n_chk++;
      if (bad != 0) begin n_fail++; $display("FAIL rstmid_resume: got %0d active cycles expected 0", bad); end
      n_chk++;
      if (fifo_empty !== 1'b1) begin n_fail++; $display("FAIL rstmid_fifo: got empty=%b expected 1", fifo_empty); end
   endtask

   initial begin
      test_reset();
      test_pair();
      test_flush();
      test_back_to_back();
      test_enable();
      test_reset_mid_frame();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
